// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

  // Operand select value meaning "take the register file read data".
  localparam logic [2:0] FWD_SEL_RF = 3'd0;

  // Widest forwarding-source chain the select helper understands.
  localparam int MAX_FWD_STAGES = 4;

  // Load-use stall FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_e;

  // Priority encode per-stage hits: the nearest stage (lowest index) wins,
  // stage k maps to select value k+1, no hit maps to the register file.
  function automatic logic [2:0] stage_sel(input logic [MAX_FWD_STAGES-1:0] hits);
    logic [2:0] sel;
    sel = FWD_SEL_RF;
    for (int k = MAX_FWD_STAGES - 1; k >= 0; k--) begin
      if (hits[k]) sel = 3'(k + 1);
    end
    return sel;
  endfunction

endpackage

// File: rtl/load_use_stall_fsm.sv
// Load-use stall sequencer: holds PC/IF-ID and bubbles ID/EX for LOAD_LAT
// cycles per detected hazard. A flush always wins and returns to IDLE.
// Optional macro FWD_HAZARD_PERF_EN adds saturating stall/event counters.
module load_use_stall_fsm
  import fwd_pkg::*;
#(
  parameter  int LOAD_LAT = 1,
  localparam int CNT_W    = $clog2(LOAD_LAT + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_hz,
  input  logic         i_flush,
  output logic         o_stall,
  output logic         o_bubble,
  output stall_state_e o_state
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]  o_stall_cycles,
  output logic [31:0]  o_load_use_events
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  stall_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stall_c;

  // State and remaining-stall counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and stall request. The first stall cycle is raised from IDLE
  // in the same cycle the hazard is seen; STALL covers the remaining cycles
  // and ignores hz because ID is frozen behind the bubble.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    if (i_flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_hz) begin
            stall_c   = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = (LOAD_LAT > 1) ? STALL : IDLE;
          end
        end
        STALL: begin
          stall_c = 1'b1;
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are held low while reset is asserted.
  assign o_stall  = stall_c & i_rst_n;
  assign o_bubble = stall_c & i_rst_n;
  assign o_state  = state;

`ifdef FWD_HAZARD_PERF_EN
  logic lu_event;
  assign lu_event = (state == IDLE) & i_hz & ~i_flush;

  // Saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cycles    <= '0;
      o_load_use_events <= '0;
    end else begin
      if (o_stall && (o_stall_cycles != 32'hFFFF_FFFF))
        o_stall_cycles <= o_stall_cycles + 32'd1;
      if (lu_event && (o_load_use_events != 32'hFFFF_FFFF))
        o_load_use_events <= o_load_use_events + 32'd1;
    end
  end
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// N-stage forwarding select, MEM-to-MEM store-data forwarding and
// load-use hazard stall control, sitting beside the ID/EX register.
// Optional macro FWD_HAZARD_PERF_EN exposes stall/event counters.
//
// Stall contract: while o_stall is high the PC and IF/ID hold their value;
// while o_bubble is high ID/EX loads a NOP. Both are asserted together for
// LOAD_LAT consecutive cycles per load-use event; i_flush drops them at once.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int REG_ADDR_W     = 5,
  parameter  int NUM_FWD_STAGES = 2,
  parameter  int LOAD_LAT       = 1,
  localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [REG_ADDR_W-1:0]                i_id_rs1,
  input  logic [REG_ADDR_W-1:0]                i_id_rs2,
  input  logic                                 i_id_uses_rs1,
  input  logic                                 i_id_uses_rs2,
  input  logic                                 i_id_is_store,
  input  logic [REG_ADDR_W-1:0]                i_idex_rd,
  input  logic                                 i_idex_memread,
  input  logic [REG_ADDR_W-1:0]                i_idex_rs1,
  input  logic [REG_ADDR_W-1:0]                i_idex_rs2,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] i_stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]            i_stg_regwrite,
  input  logic                                 i_exmem_memwrite,
  input  logic [REG_ADDR_W-1:0]                i_exmem_rs2,
  input  logic                                 i_memwb_memread,
  input  logic                                 i_flush,
  output logic [SEL_W-1:0]                     o_fwd_a,
  output logic [SEL_W-1:0]                     o_fwd_b,
  output logic                                 o_fwd_store,
  output logic                                 o_stall,
  output logic                                 o_bubble,
  output stall_state_e                         o_stall_state
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]                          o_stall_cycles,
  output logic [31:0]                          o_load_use_events
`endif
);

  // Only a 1-cycle load can hand its data to a directly following store
  // through the MEM stage store-data mux, so only then is the store exempt.
  localparam logic STORE_EXEMPT_EN = (LOAD_LAT == 1);

  logic [MAX_FWD_STAGES-1:0] hit_a, hit_b;
  logic [REG_ADDR_W-1:0]     memwb_rd;
  logic                      rs1_match, rs2_match, rs2_exempt, hz;

  // Per-stage operand match; stages beyond NUM_FWD_STAGES never hit.
  for (genvar k = 0; k < MAX_FWD_STAGES; k++) begin : g_hit
    if (k < NUM_FWD_STAGES) begin : g_used
      logic [REG_ADDR_W-1:0] stg_rd_k;
      logic                  live_k;
      assign stg_rd_k = i_stg_rd[k*REG_ADDR_W +: REG_ADDR_W];
      assign live_k   = i_stg_regwrite[k] & (stg_rd_k != '0);
      assign hit_a[k] = live_k & (stg_rd_k == i_idex_rs1);
      assign hit_b[k] = live_k & (stg_rd_k == i_idex_rs2);
    end else begin : g_unused
      assign hit_a[k] = 1'b0;
      assign hit_b[k] = 1'b0;
    end
  end

  assign o_fwd_a = SEL_W'(stage_sel(hit_a));
  assign o_fwd_b = SEL_W'(stage_sel(hit_b));

  // Store in MEM takes its data from the load now in WB (stage 1).
  assign memwb_rd    = i_stg_rd[REG_ADDR_W +: REG_ADDR_W];
  assign o_fwd_store = i_exmem_memwrite & i_memwb_memread & (memwb_rd != '0) &
                       (memwb_rd == i_exmem_rs2) & i_stg_regwrite[1];

  // Load-use hazard detect against the instruction in ID.
  assign rs1_match  = (i_id_rs1 == i_idex_rd);
  assign rs2_match  = (i_id_rs2 == i_idex_rd);
  assign rs2_exempt = i_id_is_store & STORE_EXEMPT_EN & ~rs1_match;
  assign hz = i_idex_memread & (i_idex_rd != '0) &
              ((i_id_uses_rs1 & rs1_match) |
               (i_id_uses_rs2 & rs2_match & ~rs2_exempt));

  load_use_stall_fsm #(
    .LOAD_LAT (LOAD_LAT)
  ) u_stall_fsm (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_hz              (hz),
    .i_flush           (i_flush),
    .o_stall           (o_stall),
    .o_bubble          (o_bubble),
    .o_state           (o_stall_state)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .o_stall_cycles    (o_stall_cycles),
    .o_load_use_events (o_load_use_events)
`endif
  );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances sharing one stimulus stream.
//   a: NUM_FWD_STAGES=3, LOAD_LAT=1
//   b: NUM_FWD_STAGES=4, LOAD_LAT=3
//   c: NUM_FWD_STAGES=3, LOAD_LAT=2
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  localparam int W = 23;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [4:0]  id_rs1, id_rs2, idex_rd, idex_rs1, idex_rs2, exmem_rs2;
  logic        id_uses_rs1, id_uses_rs2, id_is_store, idex_memread;
  logic        exmem_memwrite, memwb_memread, flush;
  logic [19:0] stg_rd;
  logic [3:0]  stg_we;

  // Outputs
  logic [1:0] a_fa, a_fb, c_fa, c_fb;
  logic [2:0] b_fa, b_fb;
  logic       a_st, a_stl, a_bub, b_st, b_stl, b_bub, c_st, c_stl, c_bub;
  stall_state_e a_state, b_state, c_state;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] a_cyc, a_ev, b_cyc, b_ev, c_cyc, c_ev;
`endif

  logic [W-1:0] obs;
  assign obs = {a_fa, a_fb, a_st, a_stl, a_bub,
                b_fa, b_fb, b_st, b_stl, b_bub,
                c_fa, c_fb, c_st, c_stl, c_bub};

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_FWD_STAGES(3), .LOAD_LAT(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2), .i_id_is_store(id_is_store),
    .i_idex_rd(idex_rd), .i_idex_memread(idex_memread), .i_idex_rs1(idex_rs1), .i_idex_rs2(idex_rs2),
    .i_stg_rd(stg_rd[14:0]), .i_stg_regwrite(stg_we[2:0]), .i_exmem_memwrite(exmem_memwrite),
    .i_exmem_rs2(exmem_rs2), .i_memwb_memread(memwb_memread), .i_flush(flush),
    .o_fwd_a(a_fa), .o_fwd_b(a_fb), .o_fwd_store(a_st), .o_stall(a_stl), .o_bubble(a_bub),
    .o_stall_state(a_state)
`ifdef FWD_HAZARD_PERF_EN
    , .o_stall_cycles(a_cyc), .o_load_use_events(a_ev)
`endif
  );

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_FWD_STAGES(4), .LOAD_LAT(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2), .i_id_is_store(id_is_store),
    .i_idex_rd(idex_rd), .i_idex_memread(idex_memread), .i_idex_rs1(idex_rs1), .i_idex_rs2(idex_rs2),
    .i_stg_rd(stg_rd), .i_stg_regwrite(stg_we), .i_exmem_memwrite(exmem_memwrite),
    .i_exmem_rs2(exmem_rs2), .i_memwb_memread(memwb_memread), .i_flush(flush),
    .o_fwd_a(b_fa), .o_fwd_b(b_fb), .o_fwd_store(b_st), .o_stall(b_stl), .o_bubble(b_bub),
    .o_stall_state(b_state)
`ifdef FWD_HAZARD_PERF_EN
    , .o_stall_cycles(b_cyc), .o_load_use_events(b_ev)
`endif
  );

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_FWD_STAGES(3), .LOAD_LAT(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2), .i_id_is_store(id_is_store),
    .i_idex_rd(idex_rd), .i_idex_memread(idex_memread), .i_idex_rs1(idex_rs1), .i_idex_rs2(idex_rs2),
    .i_stg_rd(stg_rd[14:0]), .i_stg_regwrite(stg_we[2:0]), .i_exmem_memwrite(exmem_memwrite),
    .i_exmem_rs2(exmem_rs2), .i_memwb_memread(memwb_memread), .i_flush(flush),
    .o_fwd_a(c_fa), .o_fwd_b(c_fb), .o_fwd_store(c_st), .o_stall(c_stl), .o_bubble(c_bub),
    .o_stall_state(c_state)
`ifdef FWD_HAZARD_PERF_EN
    , .o_stall_cycles(c_cyc), .o_load_use_events(c_ev)
`endif
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;

  // Expected vector: forwarding selects for the 3-stage (a, c) and 4-stage (b)
  // instances, shared store-forward bit, and per-instance stall (= bubble).
  function automatic logic [W-1:0] mk(input int fa3, input int fb3, input int fa4, input int fb4,
                                      input logic st, input logic sa, input logic sb, input logic sc);
    return {2'(fa3), 2'(fb3), st, sa, sa,
            3'(fa4), 3'(fb4), st, sb, sb,
            2'(fa3), 2'(fb3), st, sc, sc};
  endfunction

  // Driver tasks
  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_is_store = 1'b0;
    idex_rd = '0; idex_memread = 1'b0; idex_rs1 = '0; idex_rs2 = '0;
    stg_rd = '0; stg_we = '0; exmem_memwrite = 1'b0; exmem_rs2 = '0;
    memwb_memread = 1'b0; flush = 1'b0;
  endtask

  task automatic set_stg(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] r3, input logic [3:0] we);
    stg_rd = {r3, r2, r1, r0};
    stg_we = we;
  endtask

  task automatic hz_rs1();
    idex_rd = 5'd7; idex_memread = 1'b1; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
  endtask

  task automatic step(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  // Cycles after a hazard cycle when nothing else happens.
  task automatic tail(input string nm);
    clr(); step({nm, "_c2"}, mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    clr(); step({nm, "_c3"}, mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    clr(); step({nm, "_c4"}, mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled on the falling edge.
  task automatic monitor();
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if (obs !== e) begin
          n_miss++;
          $display("FAIL %s: got %h expected %h", nm, obs, e);
        end
      end
    end
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;

    // Reset
    clr(); step("reset_idle", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rs1 = 5'd5; set_stg(5'd5, 0, 0, 0, 4'b0001);
    step("reset_fwd_follows", mk(1, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Forwarding selects
    clr(); idex_rs1 = 5'd5; set_stg(5'd5, 5'd5, 0, 0, 4'b0011);
    step("fwd_near_wins", mk(1, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rs1 = 5'd5; set_stg(5'd5, 5'd5, 0, 0, 4'b0010);
    step("fwd_stage1", mk(2, 0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rs1 = 5'd0; set_stg(0, 0, 0, 0, 4'b1111);
    step("fwd_rd_zero", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rs2 = 5'd9; set_stg(0, 0, 5'd9, 0, 4'b0100);
    step("fwd_stage2_b", mk(0, 3, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rs1 = 5'd12; set_stg(0, 0, 0, 5'd12, 4'b1000);
    step("fwd_stage3_only4", mk(0, 0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rs1 = 5'd3; idex_rs2 = 5'd4; set_stg(5'd4, 5'd3, 5'd3, 0, 4'b0111);
    step("fwd_both_ops", mk(2, 1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rs1 = 5'd6; set_stg(5'd6, 5'd6, 5'd6, 5'd6, 4'b0000);
    step("fwd_we_off", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Store-data forwarding
    clr(); exmem_memwrite = 1'b1; exmem_rs2 = 5'd7; memwb_memread = 1'b1; set_stg(0, 5'd7, 0, 0, 4'b0010);
    step("st_fwd_hit", mk(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    clr(); exmem_memwrite = 1'b1; exmem_rs2 = 5'd7; memwb_memread = 1'b0; set_stg(0, 5'd7, 0, 0, 4'b0010);
    step("st_fwd_no_load", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); exmem_memwrite = 1'b1; exmem_rs2 = 5'd8; memwb_memread = 1'b1; set_stg(0, 5'd7, 0, 0, 4'b0010);
    step("st_fwd_rs2_diff", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); exmem_memwrite = 1'b1; exmem_rs2 = 5'd0; memwb_memread = 1'b1; set_stg(0, 0, 0, 0, 4'b0010);
    step("st_fwd_rd0", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); exmem_memwrite = 1'b1; exmem_rs2 = 5'd7; memwb_memread = 1'b1; set_stg(5'd7, 0, 0, 0, 4'b0001);
    step("st_fwd_stage0", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Load-use on rs1, then the consumer takes the load result from stage 1
    clr(); hz_rs1(); step("lu_rs1", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    clr(); idex_rs1 = 5'd7; set_stg(0, 5'd7, 0, 0, 4'b0010);
    step("lu_rs1_c2", mk(2, 0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    clr(); step("lu_rs1_c3", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    clr(); step("lu_rs1_c4", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Store whose only dependency is rs2: exempt only at LOAD_LAT=1
    clr(); idex_rd = 5'd7; idex_memread = 1'b1;
    id_rs1 = 5'd2; id_rs2 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_is_store = 1'b1;
    step("st_exempt", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    clr(); idex_rs1 = 5'd2; idex_rs2 = 5'd7; set_stg(5'd7, 0, 0, 0, 4'b0001);
    step("st_exempt_ex", mk(0, 1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1));
    clr(); exmem_memwrite = 1'b1; exmem_rs2 = 5'd7; memwb_memread = 1'b1; set_stg(0, 5'd7, 0, 0, 4'b0010);
    step("st_exempt_mem", mk(0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0));
    clr(); step("st_exempt_done", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Store that also needs the load on rs1 is never exempt
    clr(); idex_rd = 5'd7; idex_memread = 1'b1;
    id_rs1 = 5'd7; id_rs2 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_is_store = 1'b1;
    step("st_rs1_dep", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    tail("st_rs1_dep");

    // No hazard cases
    clr(); idex_rd = 5'd0; idex_memread = 1'b1; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    step("lu_rd0", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rd = 5'd7; idex_memread = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd7;
    step("lu_unused", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); idex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    step("lu_no_load", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Flush in the second stall cycle, and flush together with a hazard
    clr(); idex_rd = 5'd4; idex_memread = 1'b1; id_rs2 = 5'd4; id_uses_rs2 = 1'b1;
    step("fl_start", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    clr(); flush = 1'b1; step("fl_cut", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); step("fl_after", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); hz_rs1(); flush = 1'b1; step("fl_same", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); step("fl_same_next", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset during STALL, then a fresh hazard gets a full stall
    clr(); hz_rs1(); step("rs_start", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    clr(); rst_n = 1'b0; step("rs_assert", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); rst_n = 1'b1; step("rs_release", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    clr(); hz_rs1(); step("rs_new_hz", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    tail("rs_new_hz");

    // Two events after a clean reset
    clr(); rst_n = 1'b0; step("pf_reset", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    clr(); hz_rs1(); step("pf_ev1", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    tail("pf_ev1");
    clr(); hz_rs1(); step("pf_ev2", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    tail("pf_ev2");

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    chk("a_state_idle", 32'(a_state), 32'(IDLE));
    chk("b_state_idle", 32'(b_state), 32'(IDLE));
    chk("c_state_idle", 32'(c_state), 32'(IDLE));
`ifdef FWD_HAZARD_PERF_EN
    chk("a_load_use_events", a_ev, 32'd2);
    chk("a_stall_cycles", a_cyc, 32'd2);
    chk("b_load_use_events", b_ev, 32'd2);
    chk("b_stall_cycles", b_cyc, 32'd6);
    chk("c_load_use_events", c_ev, 32'd2);
    chk("c_stall_cycles", c_cyc, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the 2-stage forwarding unit.
- Combines N-stage priority forwarding selects for the EX operands with correct MEM-to-MEM store-data forwarding.
- Adds a sequential load-use hazard FSM that stalls IF/ID and bubbles ID/EX for a configurable load latency.
- Sits beside the ID/EX register. It drives the EX operand muxes, the store-data mux in MEM, and the PC/IF-ID enables and ID/EX flush.

Parameters:
- REG_ADDR_W, 5, register-index width.
- NUM_FWD_STAGES, 2, number of forwarding-source stages after EX. Stage 0 = EX/MEM, stage 1 = MEM/WB, and so on. Legal range 2..4.
- LOAD_LAT, 1, stall cycles required when a consumer directly follows a load. Legal range 1..3. Constraint: NUM_FWD_STAGES >= LOAD_LAT+1.
- SEL_W, $clog2(NUM_FWD_STAGES+1), width of the forward-select outputs. Derived; not to be overridden.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_id_rs1, i_id_rs2  in  REG_ADDR_W each  source registers of the instruction in ID
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2
- i_id_is_store  in  1  ID instruction is a store
- i_idex_rd  in  REG_ADDR_W  destination of the instruction in EX
- i_idex_memread  in  1  instruction in EX is a load
- i_idex_rs1, i_idex_rs2  in  REG_ADDR_W each  sources of the instruction in EX
- i_stg_rd  in  NUM_FWD_STAGES*REG_ADDR_W  packed destinations; stage k occupies bits [k*REG_ADDR_W +: REG_ADDR_W]
- i_stg_regwrite  in  NUM_FWD_STAGES  per-stage RegWrite
- i_exmem_memwrite  in  1  instruction in EX/MEM is a store
- i_exmem_rs2  in  REG_ADDR_W  store-data source of the EX/MEM store
- i_memwb_memread  in  1  instruction in MEM/WB is a load
- i_flush  in  1  taken branch/jump; kills ID and EX
- o_fwd_a, o_fwd_b  out  SEL_W each  operand select: 0 = register file, k = stage k-1
- o_fwd_store  out  1  select MEM/WB load data as store data
- o_stall  out  1  hold PC and IF/ID
- o_bubble  out  1  load NOP into ID/EX

Behaviour:
- Reset: o_stall = 0, o_bubble = 0, FSM = IDLE, counter = 0. The combinational outputs follow their inputs.
- o_fwd_a: equals the smallest k+1 such that i_stg_regwrite[k] is set, stage rd != 0, and stage rd == i_idex_rs1; otherwise 0. The nearest stage always wins.
- o_fwd_b: same rule, using i_idex_rs2.
- o_fwd_store = i_exmem_memwrite & i_memwb_memread & (MEM/WB rd != 0) & (MEM/WB rd == i_exmem_rs2) & i_stg_regwrite[1]. MEM/WB rd is stage 1.
- Hazard detect (hz) = i_idex_memread & (i_idex_rd != 0) & ((i_id_uses_rs1 & rs1 match) | (i_id_uses_rs2 & rs2 match & !(i_id_is_store & LOAD_LAT==1 & !rs1 match))).
  - The store exemption means a store whose only dependency is rs2 on the load is served by o_fwd_store, so no stall.
- FSM states: IDLE, STALL.
  - IDLE & hz & !i_flush: o_stall = o_bubble = 1 this cycle, counter <= LOAD_LAT-1. Go to STALL if LOAD_LAT > 1, else stay in IDLE.
  - STALL: o_stall = o_bubble = 1, counter decrements each cycle, and hz is ignored. When counter == 1, the next state is IDLE.
  - Total stall per event = LOAD_LAT cycles.
- i_flush: has priority. It forces o_stall = o_bubble = 0 in the same cycle and sets the next state to IDLE with counter 0, from any state.
- Simultaneous hz and i_flush: no stall.
- Reset asserted mid-STALL: next cycle is IDLE, outputs 0.
- The counter is $clog2(LOAD_LAT+1) bits wide and cannot wrap, since it is reloaded only in IDLE.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined: adds outputs o_stall_cycles [31:0] and o_load_use_events [31:0].
  - o_stall_cycles increments on every cycle with o_stall = 1.
  - o_load_use_events increments on every IDLE cycle with hz & !i_flush.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined: the ports and registers do not exist, and functional behaviour is identical.

Decomposition:
- Package fwd_pkg holds:
  - FWD_SEL_RF = 0
  - the stage-select helper function
  - the stall FSM state enum (IDLE, STALL)
- Sub-module load_use_stall_fsm: takes hz, i_flush, clock and reset; outputs o_stall and o_bubble; owns the counter and optional perf counters.
- The forwarding-select logic stays in the top module.

Test Plan:
- NUM_FWD_STAGES=3, rs1=5, stage0 rd=5 RegWrite=1, stage1 rd=5 RegWrite=1 -> o_fwd_a = 1. Same with stage0 RegWrite=0 -> o_fwd_a = 2. With rd=0 in all stages -> o_fwd_a = 0.
- LOAD_LAT=1, EX load rd=7, ID add rs1=7 -> o_stall = o_bubble = 1 for exactly 1 cycle, then 0 with o_fwd_a = 2.
- LOAD_LAT=1, EX load rd=7, ID store rs2=7 rs1=2 -> no stall. Two cycles later, o_fwd_store = 1.
- LOAD_LAT=3, load-use on rs2 -> exactly 3 consecutive stall cycles. i_flush in the second cycle -> o_stall = 0 in that cycle and IDLE thereafter.
- i_rst_n low during STALL -> the next cycle shows o_stall = 0 and a new hazard gets a full LOAD_LAT stall.
- FWD_HAZARD_PERF_EN defined, two LOAD_LAT=2 events -> o_load_use_events = 2, o_stall_cycles = 4.
